// File: rtl/dsp_spi_regbank.sv
// Register bank behind the DSP SPI slave: re-times SCK-domain write strobes into sys_clk,
// holds control/status/interrupt registers and drives read data back to the slave.
module dsp_spi_regbank #(
  parameter logic [7:0]  VERSION     = 8'h11,
  parameter logic [47:0] CTRL_RESET  = 48'h0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        spi_cs,
  input  logic        spi_rw,
  input  logic [7:0]  spi_addr,
  input  logic [7:0]  spi_data_w,
  input  logic        spi_rdy,
  output logic [7:0]  spi_data_r,
  output logic [47:0] ctrl_out,
  input  logic [31:0] stat_in,
  input  logic [7:0]  irq_in,
  output logic        irq_out,
  output logic [1:0]  fsm_state_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COMMIT   = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;

  logic [SYNC_STAGES-1:0] rdy_sync_q, cs_sync_q;
  logic [31:0]            stat_sync_q [SYNC_STAGES];
  logic                   rdy_s, cs_s, rdy_d_q;
  logic [31:0]            stat_s;

  logic [1:0]  state_q, state_d;
  logic        hold_rw_q, hold_rw_d;
  logic [7:0]  hold_addr_q, hold_addr_d, hold_data_q, hold_data_d;
  logic [7:0]  scratch_q, scratch_d, flag_q, flag_d, mask_q, mask_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d, flag_clr;
  logic [47:0] ctrl_q, ctrl_d;
  logic        irq_q, wr_ok;
  logic [7:0]  rd_data, data_r_q;

  assign rdy_s       = rdy_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign stat_s      = stat_sync_q[SYNC_STAGES-1];
  assign ctrl_out    = ctrl_q;
  assign irq_out     = irq_q;
  assign spi_data_r  = data_r_q;
  assign fsm_state_o = state_q;

  // Strobe edge detect on the synchronised rdy; the address/data are held stable by the
  // slave for the whole rdy pulse, so they are captured directly without synchronisers.
  always_comb begin
    state_d     = state_q;
    hold_rw_d   = hold_rw_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    scratch_d   = scratch_q;
    ctrl_d      = ctrl_q;
    mask_d      = mask_q;
    wr_cnt_d    = wr_cnt_q;
    err_cnt_d   = err_cnt_q;
    flag_clr    = 8'h00;
    wr_ok       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy_s && !rdy_d_q && !cs_s) begin
          hold_rw_d   = spi_rw;
          hold_addr_d = spi_addr;
          hold_data_d = spi_data_w;
          state_d     = COMMIT;
        end
      end
      COMMIT: begin
        state_d = WAIT_LOW;
        if (!hold_rw_q) begin
          wr_ok = 1'b1;
          case (hold_addr_q[6:0])
            7'h01:   scratch_d       = hold_data_q;
            7'h02:   ctrl_d[7:0]     = hold_data_q;
            7'h03:   ctrl_d[15:8]    = hold_data_q;
            7'h04:   ctrl_d[23:16]   = hold_data_q;
            7'h05:   ctrl_d[31:24]   = hold_data_q;
            7'h06:   ctrl_d[39:32]   = hold_data_q;
            7'h07:   ctrl_d[47:40]   = hold_data_q;
            7'h0C:   flag_clr        = hold_data_q;
            7'h0D:   mask_d          = hold_data_q;
            default: wr_ok           = 1'b0;
          endcase
          // Writes to read-only or unmapped addresses only bump the error counter.
          if (wr_ok) begin
            wr_cnt_d = wr_cnt_q + 8'd1;
          end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      WAIT_LOW: begin
        if (!rdy_s || cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    flag_d = (flag_q & ~flag_clr) | irq_in;
  end

  always_comb begin
    rd_data = 8'h00;
    case (spi_addr[6:0])
      7'h00:   rd_data = VERSION;
      7'h01:   rd_data = scratch_q;
      7'h02:   rd_data = ctrl_q[7:0];
      7'h03:   rd_data = ctrl_q[15:8];
      7'h04:   rd_data = ctrl_q[23:16];
      7'h05:   rd_data = ctrl_q[31:24];
      7'h06:   rd_data = ctrl_q[39:32];
      7'h07:   rd_data = ctrl_q[47:40];
      7'h08:   rd_data = stat_s[7:0];
      7'h09:   rd_data = stat_s[15:8];
      7'h0A:   rd_data = stat_s[23:16];
      7'h0B:   rd_data = stat_s[31:24];
      7'h0C:   rd_data = flag_q;
      7'h0D:   rd_data = mask_q;
      7'h0E:   rd_data = wr_cnt_q;
      7'h0F:   rd_data = err_cnt_q;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rdy_sync_q  <= '0;
      cs_sync_q   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) stat_sync_q[i] <= 32'h0;
      rdy_d_q     <= 1'b0;
      state_q     <= IDLE;
      hold_rw_q   <= 1'b0;
      hold_addr_q <= 8'h00;
      hold_data_q <= 8'h00;
      scratch_q   <= 8'h00;
      ctrl_q      <= CTRL_RESET;
      flag_q      <= 8'h00;
      mask_q      <= 8'h00;
      wr_cnt_q    <= 8'h00;
      err_cnt_q   <= 8'h00;
      irq_q       <= 1'b0;
      data_r_q    <= 8'h00;
    end else begin
      rdy_sync_q  <= {rdy_sync_q[SYNC_STAGES-2:0], spi_rdy};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      stat_sync_q[0] <= stat_in;
      for (int i = 1; i < SYNC_STAGES; i++) stat_sync_q[i] <= stat_sync_q[i-1];
      rdy_d_q     <= rdy_s;
      state_q     <= state_d;
      hold_rw_q   <= hold_rw_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      scratch_q   <= scratch_d;
      ctrl_q      <= ctrl_d;
      flag_q      <= flag_d;
      mask_q      <= mask_d;
      wr_cnt_q    <= wr_cnt_d;
      err_cnt_q   <= err_cnt_d;
      irq_q       <= |(flag_q & mask_q);
      data_r_q    <= rd_data;
    end
  end

endmodule

// File: tb/tb_dsp_spi_regbank.sv
// Directed bench for dsp_spi_regbank: SPI driver tasks queue expected values and a
// negedge monitor pops and compares them against the selected DUT output.
module tb_dsp_spi_regbank;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        spi_cs = 1'b1, spi_rw = 1'b0, spi_rdy = 1'b0;
  logic [7:0]  spi_addr = 8'h00, spi_data_w = 8'h00, irq_in = 8'h00;
  logic [31:0] stat_in = 32'h1234_5678;
  logic [7:0]  spi_data_r;
  logic [47:0] ctrl_out;
  logic        irq_out;
  logic [1:0]  fsm_state_o;

  // Check selectors for the monitor
  localparam int SEL_DATA = 0, SEL_IRQ = 1, SEL_CTRL = 2, SEL_FSM = 3;

  logic [47:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  logic        chk_req = 1'b0;
  int          checks_total = 0, checks_passed = 0;
  logic [47:0] mon_act, mon_exp;
  int          mon_sel;
  string       mon_name;

  dsp_spi_regbank dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_cs(spi_cs), .spi_rw(spi_rw),
    .spi_addr(spi_addr), .spi_data_w(spi_data_w), .spi_rdy(spi_rdy),
    .spi_data_r(spi_data_r), .ctrl_out(ctrl_out), .stat_in(stat_in),
    .irq_in(irq_in), .irq_out(irq_out), .fsm_state_o(fsm_state_o)
  );

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Driver tasks
  task automatic expect_val(input int sel, input logic [47:0] exp, input string name);
    exp_q.push_back(exp);
    sel_q.push_back(sel);
    name_q.push_back(name);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic spi_write(input logic [7:0] addr, input logic [7:0] data,
                           input logic [7:0] irq_v, input logic rst_at_commit,
                           input logic cs_hi);
    logic dropped;
    dropped    = 1'b0;
    spi_cs     = cs_hi;
    spi_rw     = 1'b0;
    spi_addr   = addr;
    spi_data_w = data;
    spi_rdy    = 1'b1;
    for (int i = 0; i < 8 && !dropped; i++) begin
      if (i == 3) begin
        irq_in  = irq_v;
        sys_rst = rst_at_commit;
        if (rst_at_commit) spi_rdy = 1'b0;
      end
      tick();
      irq_in  = 8'h00;
      if (sys_rst) dropped = 1'b1;
      sys_rst = 1'b0;
    end
    spi_rdy = 1'b0;
    tick(2);
    spi_cs = 1'b1;
    tick(6);
  endtask

  task automatic spi_read(input logic [7:0] addr, input logic [7:0] exp, input string name);
    spi_cs   = 1'b0;
    spi_rw   = 1'b1;
    spi_addr = addr;
    spi_rdy  = 1'b1;
    tick(8);
    expect_val(SEL_DATA, {40'h0, exp}, name);
    spi_rdy = 1'b0;
    tick(2);
    spi_cs = 1'b1;
    tick(6);
  endtask

  // Scoreboard monitor
  always @(negedge sys_clk) begin
    if (chk_req) begin
      checks_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL monitor: check requested with empty expected queue");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_sel  = sel_q.pop_front();
        mon_name = name_q.pop_front();
        case (mon_sel)
          SEL_DATA: mon_act = {40'h0, spi_data_r};
          SEL_IRQ:  mon_act = {47'h0, irq_out};
          SEL_CTRL: mon_act = ctrl_out;
          default:  mon_act = {46'h0, fsm_state_o};
        endcase
        if (mon_act === mon_exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", mon_name, mon_act, mon_exp);
      end
    end
  end

  initial begin
    tick(4);
    sys_rst = 1'b0;
    tick(2);

    // Reset state
    expect_val(SEL_IRQ, 48'h0, "rst_irq_out");
    expect_val(SEL_CTRL, 48'h0, "rst_ctrl_out");
    expect_val(SEL_FSM, 48'h0, "rst_fsm_idle");
    spi_read(8'h00, 8'h11, "version");
    spi_read(8'h0E, 8'h00, "rst_wr_cnt");

    // Control writes
    spi_write(8'h02, 8'hA5, 8'h00, 1'b0, 1'b0);
    spi_write(8'h07, 8'h3C, 8'h00, 1'b0, 1'b0);
    expect_val(SEL_CTRL, 48'h3C00_0000_00A5, "ctrl_out_after_writes");
    spi_read(8'h0E, 8'h02, "wr_cnt_two");
    spi_read(8'h07, 8'h3C, "ctrl_reg07");
    spi_read(8'h02, 8'hA5, "ctrl_reg02");

    // RO and unmapped writes
    spi_write(8'h08, 8'hFF, 8'h00, 1'b0, 1'b0);
    spi_write(8'h20, 8'h12, 8'h00, 1'b0, 1'b0);
    spi_read(8'h08, 8'h78, "stat_unchanged");
    spi_read(8'h0F, 8'h02, "err_cnt_two");
    spi_read(8'h0E, 8'h02, "wr_cnt_unchanged");
    spi_read(8'h20, 8'h00, "unmapped_read");
    spi_read(8'h7F, 8'h00, "unmapped_read_top");

    // Interrupts
    spi_write(8'h0D, 8'h04, 8'h00, 1'b0, 1'b0);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    tick(3);
    expect_val(SEL_IRQ, 48'h1, "irq_out_set");
    spi_read(8'h0C, 8'h04, "irq_flag_set");
    spi_write(8'h0C, 8'h04, 8'h00, 1'b0, 1'b0);
    spi_read(8'h0C, 8'h00, "irq_flag_cleared");
    expect_val(SEL_IRQ, 48'h0, "irq_out_cleared");
    spi_write(8'h0C, 8'h04, 8'h04, 1'b0, 1'b0);
    spi_read(8'h0C, 8'h04, "irq_set_wins");
    expect_val(SEL_IRQ, 48'h1, "irq_out_set_wins");
    spi_read(8'h0D, 8'h04, "irq_mask");
    spi_read(8'h0E, 8'h05, "wr_cnt_five");

    // Deselected strobe commits nothing
    spi_write(8'h01, 8'h77, 8'h00, 1'b0, 1'b1);
    spi_read(8'h01, 8'h00, "cs_high_no_write");
    spi_read(8'h0E, 8'h05, "cs_high_wr_cnt");

    // Status synchronisation
    stat_in = 32'hDEAD_BEEF;
    tick(4);
    spi_read(8'h08, 8'hEF, "stat_b0");
    spi_read(8'h09, 8'hBE, "stat_b1");
    spi_read(8'h0A, 8'hAD, "stat_b2");
    spi_read(8'h0B, 8'hDE, "stat_b3");

    // Reset during commit, then counter wrap
    spi_write(8'h01, 8'h55, 8'h00, 1'b1, 1'b0);
    expect_val(SEL_FSM, 48'h0, "fsm_idle_after_rst");
    expect_val(SEL_CTRL, 48'h0, "ctrl_after_rst");
    expect_val(SEL_IRQ, 48'h0, "irq_after_rst");
    spi_read(8'h01, 8'h00, "scratch_dropped");
    spi_read(8'h0F, 8'h00, "err_cnt_after_rst");
    for (int i = 0; i < 257; i++) begin
      spi_write(8'h01, 8'(i + 1), 8'h00, 1'b0, 1'b0);
    end
    spi_read(8'h0E, 8'h01, "wr_cnt_wrap");
    spi_read(8'h01, 8'h01, "scratch_last");

    tick(2);
    if (exp_q.size() != 0) begin
      checks_total++;
      $display("FAIL leftover: %0d expected entries never compared, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
